booth_controller: RTL and testbench

BOOTH_CONTROLLER -- requirements
Module: booth_controller

---
 rtl/booth_controller.sv | 97 +++++++++
 tb/tb_booth_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier. Moore machine: every strobe is a
// registered decode of the state, so no output follows an input combinationally.
module booth_controller (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_q0,
  input  logic i_qm1,
  input  logic i_eqz,
  output logic o_ld_m,
  output logic o_clr_a,
  output logic o_clr_ff,
  output logic o_ld_q,
  output logic o_ld_a,
  output logic o_addsub,
  output logic o_sft,
  output logic o_ld_cnt,
  output logic o_dec_cnt,
  output logic o_busy,
  output logic o_done
);

  // Four state bits leave eight spare encodings; each one falls back to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOADM = 4'd1,
    ST_LOADQ = 4'd2,
    ST_EVAL  = 4'd3,
    ST_ADD   = 4'd4,
    ST_SUB   = 4'd5,
    ST_SHIFT = 4'd6,
    ST_DONE  = 4'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] w_out;
  logic [10:0] r_out;

  // Bit order: ld_m clr_a clr_ff ld_q ld_a addsub sft ld_cnt dec_cnt busy done
  function automatic logic [10:0] decode(input state_t s);
    case (s)
      ST_IDLE:  decode = 11'b000_0000_0000;
      ST_LOADM: decode = 11'b111_0000_1010;
      ST_LOADQ: decode = 11'b000_1000_0010;
      ST_EVAL:  decode = 11'b000_0000_0010;
      ST_ADD:   decode = 11'b000_0110_0010;
      ST_SUB:   decode = 11'b000_0100_0010;
      ST_SHIFT: decode = 11'b000_0001_0110;
      ST_DONE:  decode = 11'b000_0000_0011;
      default:  decode = 11'b000_0000_0000;
    endcase
  endfunction

  // Next-state selection; outputs are the decode of the state being entered.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_LOADM;
        else         w_next = ST_IDLE;
      end
      ST_LOADM: w_next = ST_LOADQ;
      ST_LOADQ: w_next = ST_EVAL;
      ST_EVAL: begin
        if (i_eqz)                        w_next = ST_DONE;
        else if ({i_q0, i_qm1} == 2'b01)  w_next = ST_ADD;
        else if ({i_q0, i_qm1} == 2'b10)  w_next = ST_SUB;
        else                              w_next = ST_SHIFT;
      end
      ST_ADD:   w_next = ST_SHIFT;
      ST_SUB:   w_next = ST_SHIFT;
      ST_SHIFT: w_next = ST_EVAL;
      ST_DONE: begin
        if (i_start) w_next = ST_DONE;
        else         w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
    w_out = decode(w_next);
  end

  // State and output registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= 11'b000_0000_0000;
    end else begin
      r_state <= w_next;
      r_out   <= w_out;
    end
  end

  assign {o_ld_m, o_clr_a, o_clr_ff, o_ld_q, o_ld_a, o_addsub,
          o_sft, o_ld_cnt, o_dec_cnt, o_busy, o_done} = r_out;

endmodule

// File: tb/tb_booth_controller.sv
// Bench: Booth datapath around the controller, an expected strobe trace built
// from the multiplier bits, and a per-cycle comparison against that trace.
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q0, qm1, eqz;
  logic ld_m, clr_a, clr_ff, ld_q, ld_a, addsub, sft, ld_cnt, dec_cnt, busy, done;

  booth_controller dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_q0(q0), .i_qm1(qm1), .i_eqz(eqz),
    .o_ld_m(ld_m), .o_clr_a(clr_a), .o_clr_ff(clr_ff), .o_ld_q(ld_q), .o_ld_a(ld_a),
    .o_addsub(addsub), .o_sft(sft), .o_ld_cnt(ld_cnt), .o_dec_cnt(dec_cnt),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Strobe vectors: ld_m clr_a clr_ff ld_q ld_a addsub sft ld_cnt dec_cnt busy done
  localparam logic [10:0] E_IDLE  = 11'b00000000000;
  localparam logic [10:0] E_LOADM = 11'b11100001010;
  localparam logic [10:0] E_LOADQ = 11'b00010000010;
  localparam logic [10:0] E_EVAL  = 11'b00000000010;
  localparam logic [10:0] E_ADD   = 11'b00001100010;
  localparam logic [10:0] E_SUB   = 11'b00001000010;
  localparam logic [10:0] E_SHIFT = 11'b00000010110;
  localparam logic [10:0] E_DONE  = 11'b00000000011;

  logic [10:0] expq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tot_lda = 0;
  int tot_sft = 0;
  int last_rise = -1;
  logic prev_done = 1'b0;

  // Datapath: multiplicand, 17-bit accumulator, multiplier, Q[-1], counter.
  logic [15:0] mplier = 16'h0000;
  logic [15:0] mcand  = 16'h0000;
  logic [15:0] rm = 16'h0000;
  logic [16:0] ra = 17'h00000;
  logic [15:0] rq = 16'h0000;
  logic        rqm1 = 1'b0;
  logic [4:0]  cnt = 5'd0;

  assign q0  = rq[0];
  assign qm1 = rqm1;
  assign eqz = (cnt == 5'd0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dec_cnt)     cnt <= cnt - 5'd1;
    else if (ld_cnt) cnt <= 5'd16;
    if (ld_m)   rm   <= mcand;
    if (ld_q)   rq   <= mplier;
    if (clr_ff) rqm1 <= 1'b0;
    if (clr_a)      ra <= 17'h00000;
    else if (ld_a)  ra <= addsub ? ra + {rm[15], rm} : ra - {rm[15], rm};
    if (sft) {ra, rq, rqm1} <= {ra[16], ra, rq};
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {ld_m, clr_a, clr_ff, ld_q, ld_a, addsub, sft, ld_cnt, dec_cnt, busy, done};
  endfunction

  // Per-cycle compare, invariants, and pulse/done bookkeeping.
  initial begin
    logic [10:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n)              exp_v = E_IDLE;
      else if (expq.size() > 0) exp_v = expq.pop_front();
      else                     exp_v = E_IDLE;
      vectors++;
      if (outs() !== exp_v) begin
        miscompares++;
        $display("FAIL trace cyc %0d: got %011b, expected %011b", cyc, outs(), exp_v);
      end
      check("ldcnt_and_deccnt", longint'(ld_cnt & dec_cnt), 0);
      check("addsub_without_lda", longint'(addsub & ~ld_a), 0);
      if (ld_a) tot_lda++;
      if (sft)  tot_sft++;
      if (done && !prev_done) last_rise = cyc;
      prev_done = done;
    end
  end

  // Called at posedge+2; builds the expected trace and runs one multiply.
  task automatic run_op(input logic [15:0] mq, input logic [15:0] mm, input int hold,
                        output int k, output int n_lda, output int n_sft, output int d_edge);
    logic prev;
    int base_lda, base_sft, e0;
    int pexp;
    k = 0;
    prev = 1'b0;
    expq.push_back(E_IDLE);
    expq.push_back(E_LOADM);
    expq.push_back(E_LOADQ);
    for (int i = 0; i < 16; i++) begin
      expq.push_back(E_EVAL);
      if (mq[i] != prev) begin
        k++;
        expq.push_back(mq[i] ? E_SUB : E_ADD);
      end
      expq.push_back(E_SHIFT);
      prev = mq[i];
    end
    expq.push_back(E_EVAL);
    for (int i = 0; i <= hold; i++) expq.push_back(E_DONE);
    expq.push_back(E_IDLE);
    base_lda = tot_lda;
    base_sft = tot_sft;
    mplier = mq;
    mcand  = mm;
    start  = 1'b1;
    @(posedge clk); #2;
    e0 = cyc;
    if (hold == 0) start = 1'b0;
    else begin
      repeat (35 + k + hold) @(posedge clk);
      #2 start = 1'b0;
    end
    for (int c = 0; c < 100 && expq.size() != 0; c++) begin
      @(posedge clk); #2;
    end
    check("trace_drained", longint'(expq.size()), 0);
    expq.delete();
    n_lda  = tot_lda - base_lda;
    n_sft  = tot_sft - base_sft;
    d_edge = last_rise - e0;
    pexp = int'($signed(mm)) * int'($signed(mq));
    check("done_edge", d_edge, 35 + k);
    check("lda_pulses", n_lda, k);
    check("sft_pulses", n_sft, 16);
    check("product", longint'($signed({ra[15:0], rq})), longint'(pexp));
  endtask

  initial begin
    int k, nl, ns, de;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    run_op(16'h0000, 16'h1234, 0, k, nl, ns, de);
    check("pin0000_lda", nl, 0);
    check("pin0000_sft", ns, 16);
    check("pin0000_done", de, 35);

    run_op(16'h5555, 16'h7ABC, 0, k, nl, ns, de);
    check("pin5555_lda", nl, 16);
    check("pin5555_sft", ns, 16);
    check("pin5555_done", de, 51);

    run_op(16'hFFFF, 16'h8000, 0, k, nl, ns, de);
    check("pinFFFF_lda", nl, 1);
    check("pinFFFF_done", de, 36);

    // start held through the whole run and three extra DONE cycles
    run_op(16'h00F0, 16'hFFFD, 3, k, nl, ns, de);
    check("pinhold_done", de, 37);

    // reset asserted mid-cycle while the fifth SHIFT is showing
    expq.push_back(E_IDLE);
    expq.push_back(E_LOADM);
    expq.push_back(E_LOADQ);
    for (int i = 0; i < 4; i++) begin
      expq.push_back(E_EVAL);
      expq.push_back(E_SHIFT);
    end
    expq.push_back(E_EVAL);
    mplier = 16'h0000;
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 check("pre_reset_sft", longint'(sft), 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset_outs", longint'(outs()), 0);
    check("reset_queue_used", longint'(expq.size()), 0);
    expq.delete();
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(16'h0000, 16'h0101, 0, k, nl, ns, de);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), k, nl, ns, de);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
